// File: rtl/freq_gate_gen.sv
// Avalon-MM slave producing the frequency-meter gate window on out_port (single or continuous).
// Read latency 1 cycle, no wait states; out_port follows the FSM state one edge after a start write.
module freq_gate_gen #(
  parameter logic [31:0] RESET_PERIOD = 32'd50000000,
  parameter logic [31:0] RESET_GAP    = 32'd1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        out_port
);

  typedef enum logic [1:0] {IDLE, GATE, GAP} state_t;

  state_t      state, state_nxt;
  logic [31:0] counter, counter_nxt;
  logic [31:0] period, gap;
  logic [31:0] period_ld, gap_ld;
  logic [31:0] rd_mux;
  logic        cont, done, irq_mask;
  logic        done_set;
  logic        wr_en, ctrl_wr, start, stop;

  assign wr_en   = chipselect & ~write_n;
  assign ctrl_wr = wr_en & (address == 2'd0);
  assign start   = ctrl_wr & writedata[0];
  assign stop    = ctrl_wr & writedata[2];

  // A zero length behaves as one cycle, so the load value saturates at 0.
  assign period_ld = (period == 32'd0) ? 32'd0 : period - 32'd1;
  assign gap_ld    = (gap == 32'd0)    ? 32'd0 : gap - 32'd1;

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    done_set    = 1'b0;
    if (stop) begin
      state_nxt   = IDLE;
      counter_nxt = 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt   = GATE;
            counter_nxt = period_ld;
          end
        end
        GATE: begin
          if (counter == 32'd0) begin
            done_set = 1'b1;
            if (cont) begin
              state_nxt   = GAP;
              counter_nxt = gap_ld;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            counter_nxt = counter - 32'd1;
          end
        end
        GAP: begin
          if (counter == 32'd0) begin
            if (cont) begin
              state_nxt   = GATE;
              counter_nxt = period_ld;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            counter_nxt = counter - 32'd1;
          end
        end
        default: begin
          state_nxt   = IDLE;
          counter_nxt = 32'd0;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (address)
      2'd0:    rd_mux = {29'd0, out_port, cont, (state != IDLE)};
      2'd1:    rd_mux = period;
      2'd2:    rd_mux = gap;
      default: rd_mux = {30'd0, irq_mask, done};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      counter  <= 32'd0;
      out_port <= 1'b0;
    end else begin
      state    <= state_nxt;
      counter  <= counter_nxt;
      out_port <= (state_nxt == GATE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period   <= RESET_PERIOD;
      gap      <= RESET_GAP;
      cont     <= 1'b0;
      irq_mask <= 1'b0;
      done     <= 1'b0;
      readdata <= 32'd0;
    end else begin
      readdata <= rd_mux;
      if (ctrl_wr) cont <= writedata[1];
      if (wr_en && address == 2'd1) period <= writedata;
      if (wr_en && address == 2'd2) gap <= writedata;
      if (wr_en && address == 2'd3) irq_mask <= writedata[1];
      // Gate-end set takes precedence over a software clear in the same cycle.
      if (done_set) done <= 1'b1;
      else if (wr_en && address == 2'd3 && writedata[0]) done <= 1'b0;
    end
  end

  assign irq = done & irq_mask;

endmodule

// File: tb/tb_freq_gate_gen.sv
// Directed bench for freq_gate_gen: register map, gate timing, continuous mode, stop and reset.
module tb_freq_gate_gen;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        out_port;

  int errors = 0;
  int checks = 0;

  freq_gate_gen #(.RESET_PERIOD(32'd50000000), .RESET_GAP(32'd1000)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Occupies exactly one cycle: the write is sampled on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_port !== 1'b0) begin errors++; $display("FAIL reset_out got %0b want 0", out_port); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", irq); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %0d want 0", readdata); end
    @(negedge clk) reset_n = 1'b1;
    rd(2'd1, d);
    checks++; if (d !== 32'd50000000) begin errors++; $display("FAIL reset_period got %0d want 50000000", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'd1000) begin errors++; $display("FAIL reset_gap got %0d want 1000", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %0h want 0", d); end
    rd(2'd3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_status got %0h want 0", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_port !== (k < 5)) begin errors++; $display("FAIL single_out k=%0d got %0b want %0b", k, out_port, (k < 5)); end
      step();
    end
    rd(2'd3, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL single_done got %0h want 1", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_ctrl got %0h want 0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq got %0b want 0", irq); end
  endtask

  task automatic test_cont();
    logic [31:0] d;
    logic        exp_irq;
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd2);
    wr(2'd3, 32'h3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cont_irq_clr got %0b want 0", irq); end
    wr(2'd0, 32'h3);
    for (int k = 0; k < 13; k++) begin
      exp_irq = (k >= 3 && k <= 4) || (k >= 8);
      checks++;
      if (out_port !== ((k % 5) < 3)) begin errors++; $display("FAIL cont_out k=%0d got %0b want %0b", k, out_port, ((k % 5) < 3)); end
      checks++;
      if (irq !== exp_irq) begin errors++; $display("FAIL cont_irq k=%0d got %0b want %0b", k, irq, exp_irq); end
      if (k == 4) wr(2'd3, 32'h3);
      else step();
    end
    wr(2'd0, 32'h4);
    rd(2'd3, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL cont_status got %0h want 3", d); end
    wr(2'd3, 32'h3);
    rd(2'd3, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL cont_clear got %0h want 2", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cont_irq_end got %0b want 0", irq); end
  endtask

  task automatic test_zero_len();
    logic [31:0] d;
    logic        exp;
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h3);
    for (int k = 0; k < 10; k++) begin
      exp = (k == 0) || (k == 2) || (k >= 4 && k <= 7) || (k == 9);
      checks++;
      if (out_port !== exp) begin errors++; $display("FAIL zero_out k=%0d got %0b want %0b", k, out_port, exp); end
      if (k == 2) wr(2'd1, 32'd4);
      else step();
    end
    wr(2'd0, 32'h4);
    rd(2'd1, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL zero_period got %0d want 4", d); end
    wr(2'd3, 32'h1);
  endtask

  task automatic test_stop();
    logic [31:0] d;
    wr(2'd1, 32'd10);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h3);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (out_port !== (k <= 3)) begin errors++; $display("FAIL stop_out k=%0d got %0b want %0b", k, out_port, (k <= 3)); end
      if (k == 3) wr(2'd0, 32'h4);
      else step();
    end
    rd(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL stop_ctrl got %0h want 0", d); end
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL stop_done got %0h want 0", d); end
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_port !== (k < 5)) begin errors++; $display("FAIL restart_out k=%0d got %0b want %0b", k, out_port, (k < 5)); end
      if (k == 2) wr(2'd0, 32'h1);
      else step();
    end
    rd(2'd3, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL restart_done got %0h want 1", d); end
    wr(2'd3, 32'h1);
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL done_clear got %0h want 0", d); end
  endtask

  task automatic test_setwins_reset();
    logic [31:0] d;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    checks++; if (out_port !== 1'b1) begin errors++; $display("FAIL setwins_out0 got %0b want 1", out_port); end
    step();
    checks++; if (out_port !== 1'b1) begin errors++; $display("FAIL setwins_out1 got %0b want 1", out_port); end
    wr(2'd3, 32'h1);
    checks++; if (out_port !== 1'b0) begin errors++; $display("FAIL setwins_out2 got %0b want 0", out_port); end
    rd(2'd3, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL setwins_done got %0h want 1", d); end

    wr(2'd1, 32'd7);
    wr(2'd2, 32'd9);
    wr(2'd3, 32'h2);
    wr(2'd0, 32'h3);
    step();
    step();
    checks++; if (out_port !== 1'b1) begin errors++; $display("FAIL midgate_out got %0b want 1", out_port); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL midgate_irq got %0b want 1", irq); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_port !== 1'b0) begin errors++; $display("FAIL arst_out got %0b want 0", out_port); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq got %0b want 0", irq); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL arst_rdata got %0h want 0", readdata); end
    @(negedge clk) reset_n = 1'b1;
    rd(2'd1, d);
    checks++; if (d !== 32'd50000000) begin errors++; $display("FAIL arst_period got %0d want 50000000", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'd1000) begin errors++; $display("FAIL arst_gap got %0d want 1000", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL arst_ctrl got %0h want 0", d); end
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL arst_status got %0h want 0", d); end
    checks++; if (out_port !== 1'b0) begin errors++; $display("FAIL arst_out_after got %0b want 0", out_port); end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    test_reset();
    test_single();
    test_cont();
    test_zero_len();
    test_stop();
    test_setwins_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_gate_gen.md
Name: freq_gate_gen

Overview:
- Avalon-MM slave that generates the frequency-meter gate (enable) window on `out_port`.
- `out_port` feeds the freq_en input PIO, which samples it and edge-captures both its rising and falling edges.
- Nios programs the gate length and the inter-gate gap, then starts a single gate or continuous gating.
- A done flag plus a maskable irq fire at each gate end.

Parameters:
- RESET_PERIOD, 50000000: gate length in clk cycles after reset (1 s at 50 MHz).
- RESET_GAP, 1000: low time between gates in continuous mode, in clk cycles, after reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  done & irq_mask
- out_port  out  1  gate output, registered

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values: readdata=0, out_port=0, irq=0, state=IDLE, done=0, irq_mask=0, cont=0, period=RESET_PERIOD, gap=RESET_GAP, counter=0.
- A write is `chipselect && !write_n`.
- Reads:
  - readdata is registered every cycle from a mux on address; latency is 1 cycle.
  - Unused bits read 0.
  - Reads have no side effects.
- Register map:
  - addr0 CONTROL.
    - Write: bit0 start, bit1 cont, bit2 stop.
    - Read: bit0 running (state!=IDLE), bit1 cont, bit2 out_port.
  - addr1 PERIOD: 32-bit read/write.
  - addr2 GAP: 32-bit read/write.
  - addr3 STATUS.
    - Read: bit0 done, bit1 irq_mask.
    - Write: bit1→irq_mask; bit0=1 clears done.
- cont: every write to addr0 loads cont from writedata bit1.
- Length rules:
  - Effective length = max(reg, 1) for both PERIOD and GAP.
  - PERIOD and GAP are latched into the down-counter only at gate or gap entry. Writes during a run take effect at the next entry.
- FSM IDLE:
  - Start write → GATE on the next edge: out_port=1, counter=effective PERIOD-1.
  - Stop write, or start and stop in the same write → stay IDLE.
- FSM GATE:
  - out_port=1; counter decrements each cycle.
  - At counter==0: done set, out_port=0 on the next edge.
  - Then go to GAP (counter=effective GAP-1) if cont=1, else go to IDLE.
  - out_port is high for exactly effective PERIOD cycles.
- FSM GAP:
  - out_port=0; counter decrements.
  - At counter==0 → GATE with a reload of PERIOD.
  - Clearing cont during GAP causes a return to IDLE at gap end, not GATE.
- Start while in GATE or GAP: ignored.
- Stop (any state):
  - Next edge: state=IDLE, out_port=0, counter=0.
  - done is NOT set by an abort.
  - Stop has priority over start and over gate-end in the same cycle.
- irq: combinational `done & irq_mask`.
- Simultaneous done set (gate end) and STATUS bit0 clear write: set wins, done=1.
- Counter: 32-bit unsigned, no wrap. It is loaded only at entry and never decremented below 0.
- Reset mid-gate: out_port drops to 0 asynchronously. All registers return to reset values.
- Edge guarantee: each gate produces exactly one rising and one falling edge on out_port. In continuous mode the minimum low time is 1 cycle.

Test Plan:
1. Reset, then read addr1 and addr2 → 50000000 and 1000; read addr0 → 0; out_port=0, irq=0.
2. PERIOD=5, write addr0=0x1 → out_port high exactly 5 cycles starting 1 cycle after the write; done=1; running=0 afterwards; irq=0 with mask clear.
3. PERIOD=3, GAP=2, STATUS mask=1, write addr0=0x3 → out_port pattern 1,1,1,0,0,1,1,1,…; irq asserts at each gate end; write addr3=0x3 clears done and keeps the mask.
4. PERIOD=0 and GAP=0, cont → out_port toggles high 1 / low 1; rewrite PERIOD=4 mid-gate → the next gate is 4 cycles long, the current one is unaffected.
5. Cont run with PERIOD=10, write addr0=0x4 at gate cycle 4 → out_port low the next cycle, state IDLE, done stays 0; a start issued 2 cycles later during GATE is ignored.
6. Single gate PERIOD=2 with a STATUS clear write landing on the gate-end cycle → done=1 (set wins). Separately, assert reset_n low mid-gate → out_port=0 immediately and all registers return to reset values.
